// File: rtl/lcd_spi_writer_pkg.sv
// Shared types and constants for the LCD SPI transmit path.
package lcd_pkg;

    localparam int unsigned WORD_W = 9;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSetup = 3'd1,
        StShift = 3'd2,
        StHold  = 3'd3,
        StDone  = 3'd4
    } state_e;

endpackage

// File: rtl/lcd_spi_writer_if.sv
// Source word/strobe, status flags and LCD pins of the SPI writer.
interface lcd_spi_writer_if;
    import lcd_pkg::*;

    logic [WORD_W-1:0] spi_data;
    logic              en_write;
    logic              lcd_sclk;
    logic              lcd_mosi;
    logic              lcd_dc;
    logic              lcd_cs_n;
    logic              busy;
    logic              wr_done;
    logic              overrun;

    modport slave (
        input  spi_data, en_write,
        output lcd_sclk, lcd_mosi, lcd_dc, lcd_cs_n, busy, wr_done, overrun
    );

    modport master (
        output spi_data, en_write,
        input  lcd_sclk, lcd_mosi, lcd_dc, lcd_cs_n, busy, wr_done, overrun
    );

endinterface

// File: rtl/spi_clk_div.sv
// Counts CLK_DIV cycles and ticks on the last one; restart_i begins a fresh count.
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic restart_i,
    output logic tick_o
);

    localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == DivLast);

    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (restart_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lcd_spi_writer.sv
// SPI mode-0 byte writer for the LCD with a one-word pending buffer.
module lcd_spi_writer
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    lcd_spi_writer_if.slave  bus
);

    state_e            state_q, state_d;
    logic [7:0]        sh_q, sh_d;
    logic [2:0]        bit_q, bit_d;
    logic [WORD_W-1:0] pend_q, pend_d;
    logic              pend_full_q, pend_full_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              dc_q, dc_d;
    logic              cs_n_q, cs_n_d;
    logic              busy_q, busy_d;
    logic              wr_done_q, wr_done_d;
    logic              overrun_q, overrun_d;
    logic [WORD_W-1:0] word;
    logic              tick;
    logic              restart;

    // Every state change restarts the divider so each state gets a full H.
    assign restart = (state_d != state_q);

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk_i     (sys_clk),
        .rst_ni    (sys_rst_n),
        .restart_i (restart),
        .tick_o    (tick)
    );

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        bit_d       = bit_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        dc_d        = dc_q;
        cs_n_d      = cs_n_q;
        overrun_d   = overrun_q;
        wr_done_d   = 1'b0;
        word        = pend_full_q ? pend_q : bus.spi_data;

        unique case (state_q)
            StIdle: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                if (pend_full_q || bus.en_write) begin
                    sh_d        = word[7:0];
                    dc_d        = word[8];
                    mosi_d      = word[7];
                    cs_n_d      = 1'b0;
                    bit_d       = '0;
                    pend_full_d = 1'b0;
                    state_d     = StSetup;
                end
            end
            StSetup: begin
                if (tick) state_d = StShift;
            end
            StShift: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    if (sclk_q) begin
                        if (bit_q == 3'd7) begin
                            state_d = StHold;
                        end else begin
                            bit_d  = bit_q + 3'd1;
                            sh_d   = {sh_q[6:0], 1'b0};
                            mosi_d = sh_q[6];
                        end
                    end
                end
            end
            StHold: begin
                if (tick) begin
                    state_d   = StDone;
                    cs_n_d    = 1'b1;
                    wr_done_d = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A strobe that IDLE does not consume goes to pending, or is dropped if it is full.
        if (bus.en_write && !(state_q == StIdle && !pend_full_q)) begin
            if (pend_full_q) begin
                overrun_d = 1'b1;
            end else begin
                pend_d      = bus.spi_data;
                pend_full_d = 1'b1;
            end
        end

        busy_d = (state_d != StIdle) || pend_full_d;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= StIdle;
            sh_q        <= '0;
            bit_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            dc_q        <= 1'b0;
            cs_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            wr_done_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            bit_q       <= bit_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            dc_q        <= dc_d;
            cs_n_q      <= cs_n_d;
            busy_q      <= busy_d;
            wr_done_q   <= wr_done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.lcd_sclk = sclk_q;
    assign bus.lcd_mosi = mosi_q;
    assign bus.lcd_dc   = dc_q;
    assign bus.lcd_cs_n = cs_n_q;
    assign bus.busy     = busy_q;
    assign bus.wr_done  = wr_done_q;
    assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_lcd_spi_writer.sv
// Scoreboard bench: expected words queued at the strobe, checked when wr_done fires.
module tb_lcd_spi_writer;

    logic sys_clk;
    logic sys_rst_n;

    lcd_spi_writer_if a ();
    lcd_spi_writer_if b ();

    lcd_spi_writer #(.CLK_DIV(2)) u_dut_a (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (a)
    );

    lcd_spi_writer #(.CLK_DIV(1)) u_dut_b (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (b)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    logic [8:0] exp_q[$];
    logic [8:0] exp_b_q[$];

    // Monitor for DUT A (H = 2): rebuilds each frame from the pins.
    int         done_cnt   = 0;
    int         rises      = 0;
    int         cs_cnt     = 0;
    int         hi_cnt     = 0;
    bit         in_frame   = 0;
    bit         seen_frame = 0;
    bit         dc_ok;
    logic       dc0;
    logic       prev_sclk  = 0;
    logic [7:0] bits;

    initial begin : monitor_a
        logic [8:0] e;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst_n) begin
                in_frame   = 0;
                seen_frame = 0;
                rises      = 0;
                prev_sclk  = 0;
            end else begin
                if (!a.lcd_cs_n) begin
                    if (!in_frame) begin
                        if (seen_frame) check("cs_gap_ge2", int'(hi_cnt >= 2), 1);
                        in_frame = 1;
                        cs_cnt   = 0;
                        rises    = 0;
                        bits     = '0;
                        dc0      = a.lcd_dc;
                        dc_ok    = 1;
                    end
                    cs_cnt++;
                    if (a.lcd_dc !== dc0) dc_ok = 0;
                    if (a.lcd_sclk && !prev_sclk) begin
                        bits = {bits[6:0], a.lcd_mosi};
                        rises++;
                    end
                end else begin
                    if (in_frame) hi_cnt = 0;
                    in_frame = 0;
                    hi_cnt++;
                end
                if (a.wr_done) begin
                    seen_frame = 1;
                    done_cnt++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_wr_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", int'(bits), int'(e[7:0]));
                        check("dc", int'(dc0), int'(e[8]));
                        check("rises", rises, 8);
                        check("cs_low_cycles", cs_cnt, 36);
                        check("dc_stable", int'(dc_ok), 1);
                    end
                end
                prev_sclk = a.lcd_sclk;
            end
        end
    end

    task automatic strobe_a(input logic [8:0] w);
        @(posedge sys_clk); #1;
        a.en_write = 1'b1;
        a.spi_data = w;
        exp_q.push_back(w);
        @(posedge sys_clk); #1;
        a.en_write = 1'b0;
    endtask

    task automatic wait_done(input int target, input string tag);
        int n = 0;
        while (done_cnt < target && n < 500) begin
            @(posedge sys_clk); #1;
            n++;
        end
        if (done_cnt < target) check(tag, done_cnt, target);
    endtask

    task automatic pulse_reset();
        @(posedge sys_clk); #3;
        sys_rst_n = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge sys_clk);
        #3 sys_rst_n = 1'b1;
    endtask

    initial begin : stim
        int         n;
        int         base;
        bit         busy_ok;
        logic [8:0] e;
        int         cs, r, first, per;
        bit         got_done;
        logic       prev;
        logic [7:0] bb;

        sys_rst_n  = 1'b0;
        a.en_write = 1'b0;
        a.spi_data = '0;
        b.en_write = 1'b0;
        b.spi_data = '0;
        #12;
        check("rst_sclk", int'(a.lcd_sclk), 0);
        check("rst_mosi", int'(a.lcd_mosi), 0);
        check("rst_dc", int'(a.lcd_dc), 0);
        check("rst_cs_n", int'(a.lcd_cs_n), 1);
        check("rst_busy", int'(a.busy), 0);
        check("rst_wr_done", int'(a.wr_done), 0);
        check("rst_overrun", int'(a.overrun), 0);
        @(posedge sys_clk); #3;
        sys_rst_n = 1'b1;

        // Single command: latency counted inclusive from the strobe cycle to wr_done.
        @(posedge sys_clk); #1;
        a.en_write = 1'b1;
        a.spi_data = 9'h036;
        exp_q.push_back(9'h036);
        n = 1;
        @(posedge sys_clk); #1;
        a.en_write = 1'b0;
        n = 2;
        while (!a.wr_done && n < 200) begin
            @(posedge sys_clk); #1;
            n++;
        end
        check("latency_cycles", n, 38);
        wait_done(1, "timeout_cmd");

        // Data byte.
        strobe_a(9'h1A5);
        wait_done(2, "timeout_data");

        // Back-to-back: second word waits in pending, busy never drops.
        base = done_cnt;
        strobe_a(9'h02A);
        repeat (3) @(posedge sys_clk);
        strobe_a(9'h100);
        busy_ok = 1;
        n = 0;
        while (done_cnt < base + 2 && n < 500) begin
            if (!a.busy) busy_ok = 0;
            @(posedge sys_clk); #1;
            n++;
        end
        check("b2b_frames", done_cnt - base, 2);
        check("b2b_busy_held", int'(busy_ok), 1);
        check("b2b_overrun", int'(a.overrun), 0);
        repeat (3) @(posedge sys_clk); #1;
        check("b2b_idle_busy", int'(a.busy), 0);

        // Overrun: three consecutive strobes, third dropped.
        base = done_cnt;
        @(posedge sys_clk); #1;
        a.en_write = 1'b1;
        a.spi_data = 9'h011;
        exp_q.push_back(9'h011);
        @(posedge sys_clk); #1;
        a.spi_data = 9'h122;
        exp_q.push_back(9'h122);
        @(posedge sys_clk); #1;
        a.spi_data = 9'h033;
        @(posedge sys_clk); #1;
        a.en_write = 1'b0;
        check("ovr_set", int'(a.overrun), 1);
        wait_done(base + 2, "timeout_ovr");
        repeat (20) @(posedge sys_clk); #1;
        check("ovr_frames", done_cnt - base, 2);
        check("ovr_sticky", int'(a.overrun), 1);
        pulse_reset();
        @(posedge sys_clk); #1;
        check("ovr_cleared_by_reset", int'(a.overrun), 0);

        // Reset mid-byte, during bit 4 of SHIFT.
        strobe_a(9'h0C3);
        n = 0;
        while (!(in_frame && rises == 4) && n < 100) begin
            @(posedge sys_clk); #1;
            n++;
        end
        check("reached_bit4", rises, 4);
        @(posedge sys_clk); #3;
        sys_rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_cs_n", int'(a.lcd_cs_n), 1);
        check("midrst_sclk", int'(a.lcd_sclk), 0);
        check("midrst_mosi", int'(a.lcd_mosi), 0);
        check("midrst_busy", int'(a.busy), 0);
        repeat (2) @(posedge sys_clk);
        #3 sys_rst_n = 1'b1;
        base = done_cnt;
        repeat (60) @(posedge sys_clk); #1;
        check("midrst_no_wr_done", done_cnt - base, 0);
        strobe_a(9'h155);
        wait_done(base + 1, "timeout_after_rst");

        // CLK_DIV = 1 instance.
        @(posedge sys_clk); #1;
        b.en_write = 1'b1;
        b.spi_data = 9'h0FF;
        exp_b_q.push_back(9'h0FF);
        @(posedge sys_clk); #1;
        b.en_write = 1'b0;
        cs = 0; r = 0; first = -1; per = -1; got_done = 0; prev = 1'b0; bb = '0;
        for (int i = 0; i < 60 && !got_done; i++) begin
            @(negedge sys_clk);
            if (!b.lcd_cs_n) begin
                cs++;
                if (b.lcd_sclk && !prev) begin
                    r++;
                    bb = {bb[6:0], b.lcd_mosi};
                    if (first < 0) first = i;
                    if (r == 2) per = i - first;
                end
            end
            prev = b.lcd_sclk;
            if (b.wr_done) begin
                got_done = 1;
                e = exp_b_q.pop_front();
                check("div1_byte", int'(bb), int'(e[7:0]));
                check("div1_dc", int'(b.lcd_dc), int'(e[8]));
            end
        end
        check("div1_done", int'(got_done), 1);
        check("div1_cs_low", cs, 18);
        check("div1_rises", r, 8);
        check("div1_sclk_period", per, 2);

        check("a_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
